pipe_hazard_ctrl: RTL

- Producer and consumer side of the pipeline hazard handshake.
- Tracks destination-register, write-enable and load tags through stages E/M/W and drives the register-match flags the hazard unit uses for forwarding and stall decisions.
- Takes back the hazard unit's LDRstall, plus branch-taken and data-memory-ready, and turns them into per-stage stall/flush enables for the pipeline registers.
- Sits beside the datapath between decode and the hazard unit.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: stage tag layout,
// controller state encoding and the bubble constant.
package hazard_pkg;

    localparam int REG_AW = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic [REG_AW-1:0] wa3;
        logic              regwrite;
        logic              memtoreg;
    } stage_tag_t;

    function automatic stage_tag_t tag_bubble();
        return '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // count one event per cycle, hold at saturation
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: carries E/M/W destination/write/load tags,
// produces register-match flags for the hazard unit, and turns LDRstall,
// branch-taken and data-memory-ready into per-stage stall/flush enables.
//
//   state   | meaning
//   RUN     | normal flow; stalls/flushes follow LDRstall and BranchTakenE
//   MEMWAIT | load in M waiting for data memory; F..M frozen, W gets bubbles
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = hazard_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              ValidD,
    input  logic              BranchTakenE,
    input  logic              MemReadyM,
    input  logic              LDRstall,
    output logic              Match_1E_M,
    output logic              Match_1E_W,
    output logic              Match_2E_M,
    output logic              Match_2E_W,
    output logic              Match_12D_E,
    output logic              RegWriteE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              MemtoRegE,
    output logic              MemtoRegM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    stage_tag_t        tag_d;
    stage_tag_t        tag_e;
    logic              valid_m;
    logic [REG_AW-1:0] wa3_m;
    logic              regwrite_m;
    logic              memtoreg_m;
    logic              valid_w;
    logic [REG_AW-1:0] wa3_w;
    logic              regwrite_w;
    hz_state_t         state;
    hz_state_t         state_nxt;
    logic              mem_hold;

    assign tag_d = '{valid: ValidD, ra1: RA1D, ra2: RA2D, wa3: WA3D,
                     regwrite: RegWriteD, memtoreg: MemtoRegD};

    // controller state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // next state and stall/flush enables; the MEMWAIT entry cycle already
    // freezes the pipe, and all enables are held off while in reset
    always_comb begin
        state_nxt = state;
        mem_hold  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        case (state)
            RUN: begin
                if (valid_m && memtoreg_m && !MemReadyM) begin
                    mem_hold  = 1'b1;
                    state_nxt = MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (MemReadyM)
                    state_nxt = RUN;
                else
                    mem_hold = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
        if (!reset) begin
            if (mem_hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = LDRstall;
                StallD = LDRstall;
                FlushD = BranchTakenE;
                FlushE = LDRstall | BranchTakenE;
            end
        end
    end

    // tag pipeline: advance one stage per cycle unless held, bubbles on flush
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_e      <= tag_bubble();
            valid_m    <= 1'b0;
            wa3_m      <= '0;
            regwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            valid_w    <= 1'b0;
            wa3_w      <= '0;
            regwrite_w <= 1'b0;
        end else begin
            if (FlushE)
                tag_e <= tag_bubble();
            else if (!StallE)
                tag_e <= tag_d;

            if (!StallM) begin
                valid_m    <= tag_e.valid;
                wa3_m      <= tag_e.wa3;
                regwrite_m <= tag_e.regwrite;
                memtoreg_m <= tag_e.memtoreg;
            end

            if (FlushW) begin
                valid_w    <= 1'b0;
                wa3_w      <= '0;
                regwrite_w <= 1'b0;
            end else begin
                valid_w    <= valid_m;
                wa3_w      <= wa3_m;
                regwrite_w <= regwrite_m;
            end
        end
    end

    assign Match_1E_M  = tag_e.valid & valid_m & (tag_e.ra1 == wa3_m);
    assign Match_1E_W  = tag_e.valid & valid_w & (tag_e.ra1 == wa3_w);
    assign Match_2E_M  = tag_e.valid & valid_m & (tag_e.ra2 == wa3_m);
    assign Match_2E_W  = tag_e.valid & valid_w & (tag_e.ra2 == wa3_w);
    assign Match_12D_E = ValidD & tag_e.valid &
                         ((RA1D == tag_e.wa3) | (RA2D == tag_e.wa3));

    assign RegWriteE = tag_e.valid & tag_e.regwrite;
    assign RegWriteM = valid_m & regwrite_m;
    assign RegWriteW = valid_w & regwrite_w;
    assign MemtoRegE = tag_e.valid & tag_e.memtoreg;
    assign MemtoRegM = valid_m & memtoreg_m;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushE),
        .count (FlushCnt)
    );

endmodule
